// File: rtl/sif_pkg.sv
// Shared types for the SIF bridge: the queued request record and the output FSM states.
package sif_pkg;

    localparam int SIF_DW = 16;
    localparam int SIF_AW = 16;

    typedef struct packed {
        logic [SIF_AW-1:0] addr;
        logic [SIF_DW-1:0] data;
    } sif_req_t;

    typedef enum logic {
        IDLE,
        PRESENT
    } sif_state_t;

endpackage

// File: rtl/sif_fifo.sv
// Synchronous FIFO of request records; DEPTH must be a power of 2 so the pointers wrap for free.
module sif_fifo
    import sif_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = sif_req_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wr_req,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; a slot is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_req;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sif_bridge.sv
// XA register slave with a queued, in-order write forwarder to NUM_CH WA channels.
// Define SIF_BRIDGE_STATS_EN to add the saturating drop_cnt output.
module sif_bridge
    import sif_pkg::*;
#(
    parameter int DW         = SIF_DW,
    parameter int AW         = SIF_AW,
    parameter int REG_DEPTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     xa_addr,
    input  logic [DW-1:0]     xa_data_wr,
    input  logic              xa_wr_s,
    input  logic              xa_rd_s,
    output logic [DW-1:0]     xa_data_rd,
    output logic              xa_rd_vld,
    output logic              xa_busy,
    output logic              xa_err,
    output logic [AW-1:0]     wa_addr,
    output logic [DW-1:0]     wa_data_wr,
    output logic [NUM_CH-1:0] wa_wr_s,
    input  logic [NUM_CH-1:0] wa_ready
`ifdef SIF_BRIDGE_STATS_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int RW   = $clog2(REG_DEPTH);
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t              push_req;
    req_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CNTW-1:0]   fifo_count;
    logic              ready_sel;
    logic              drop;
    logic              collide;
    logic [CW-1:0]     head_ch;
    logic [NUM_CH-1:0] head_onehot;
    logic [RW-1:0]     reg_idx;
    logic [DW-1:0]     regs [REG_DEPTH];
    sif_state_t        state;

    assign reg_idx  = xa_addr[RW-1:0];
    assign push_req = '{addr: xa_addr, data: xa_data_wr};
    assign xa_busy  = fifo_full;
    assign drop     = xa_wr_s && fifo_full;
    assign collide  = xa_wr_s && xa_rd_s;

    // Only the strobed channel's ready counts; wa_wr_s is zero in IDLE.
    assign ready_sel = |(wa_ready & wa_wr_s);
    assign fifo_pop  = !fifo_empty && (state == IDLE || ready_sel);

    if (NUM_CH > 1) begin : g_multi_ch
        assign head_ch = head.addr[AW-1 -: CW];
    end else begin : g_single_ch
        assign head_ch = '0;
    end
    assign head_onehot = NUM_CH'(1) << head_ch;

    sif_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (xa_wr_s && !fifo_full),
        .pop    (fifo_pop),
        .wr_req (push_req),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else if (xa_wr_s) begin
            regs[reg_idx] <= xa_data_wr;
        end
    end

    // A colliding read is discarded; the write alone takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa_data_rd <= '0;
            xa_rd_vld  <= 1'b0;
            xa_err     <= 1'b0;
        end else begin
            xa_rd_vld <= xa_rd_s && !xa_wr_s;
            if (xa_rd_s && !xa_wr_s) xa_data_rd <= regs[reg_idx];
            if (drop || collide)     xa_err     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wa_addr    <= '0;
            wa_data_wr <= '0;
            wa_wr_s    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        wa_addr    <= head.addr;
                        wa_data_wr <= head.data;
                        wa_wr_s    <= head_onehot;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready_sel) begin
                        if (!fifo_empty) begin
                            wa_addr    <= head.addr;
                            wa_data_wr <= head.data;
                            wa_wr_s    <= head_onehot;
                        end else begin
                            wa_wr_s <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIF_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNTW'(FIFO_DEPTH));

endmodule

// File: tb/tb_sif_bridge.sv
// Directed bench for sif_bridge: vector table for register/forward basics, then hand sequences.
module tb_sif_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] xa_addr;
    logic [15:0] xa_data_wr;
    logic        xa_wr_s;
    logic        xa_rd_s;
    logic [15:0] xa_data_rd;
    logic        xa_rd_vld;
    logic        xa_busy;
    logic        xa_err;
    logic [15:0] wa_addr;
    logic [15:0] wa_data_wr;
    logic [1:0]  wa_wr_s;
    logic [1:0]  wa_ready;
`ifdef SIF_BRIDGE_STATS_EN
    logic [7:0]  drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    sif_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_data_rd (xa_data_rd),
        .xa_rd_vld  (xa_rd_vld),
        .xa_busy    (xa_busy),
        .xa_err     (xa_err),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .wa_wr_s    (wa_wr_s),
        .wa_ready   (wa_ready)
`ifdef SIF_BRIDGE_STATS_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_vld;
        logic [15:0] exp_rd;
        logic [1:0]  exp_ws;
        logic [15:0] exp_wa;
        logic [15:0] exp_wd;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [15:0] addr, input logic [15:0] data);
        xa_wr_s    = wr;
        xa_rd_s    = rd;
        xa_addr    = addr;
        xa_data_wr = data;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        wa_ready = 2'b00;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        #12;
        check("rst_rd_vld", xa_rd_vld, 1'b0);
        check("rst_data_rd", xa_data_rd, 16'h0);
        check("rst_busy", xa_busy, 1'b0);
        check("rst_err", xa_err, 1'b0);
        check("rst_wa_wr_s", wa_wr_s, 2'b00);
        check("rst_wa_addr", wa_addr, 16'h0);
        check("rst_wa_data", wa_data_wr, 16'h0);
`ifdef SIF_BRIDGE_STATS_EN
        check("rst_drop_cnt", drop_cnt, 8'd0);
`endif
        do_reset();

        // Register file, read path, channel select and collision, with every channel ready.
        //                wr rd addr      wdata     vld rd        ws     wa        wd        busy err
        vecs[0]  = '{1, 0, 16'h0003, 16'hA5A5, 0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0, 0};
        vecs[1]  = '{0, 1, 16'h0003, 16'h0000, 1, 16'hA5A5, 2'b01, 16'h0003, 16'hA5A5, 0, 0};
        vecs[2]  = '{1, 0, 16'h8002, 16'h1111, 0, 16'hA5A5, 2'b00, 16'h0003, 16'hA5A5, 0, 0};
        vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 0, 16'hA5A5, 2'b10, 16'h8002, 16'h1111, 0, 0};
        vecs[4]  = '{0, 1, 16'h8002, 16'h0000, 1, 16'h1111, 2'b00, 16'h8002, 16'h1111, 0, 0};
        vecs[5]  = '{0, 1, 16'h0002, 16'h0000, 1, 16'h1111, 2'b00, 16'h8002, 16'h1111, 0, 0};
        vecs[6]  = '{1, 1, 16'h0005, 16'hBEEF, 0, 16'h1111, 2'b00, 16'h8002, 16'h1111, 0, 1};
        vecs[7]  = '{0, 1, 16'h0005, 16'h0000, 1, 16'hBEEF, 2'b01, 16'h0005, 16'hBEEF, 0, 1};
        vecs[8]  = '{0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 2'b00, 16'h0005, 16'hBEEF, 0, 1};
        vecs[9]  = '{0, 1, 16'h0013, 16'h0000, 1, 16'hA5A5, 2'b00, 16'h0005, 16'hBEEF, 0, 1};
        vecs[10] = '{1, 0, 16'h8013, 16'h7777, 0, 16'hA5A5, 2'b00, 16'h0005, 16'hBEEF, 0, 1};
        vecs[11] = '{0, 1, 16'h0003, 16'h0000, 1, 16'h7777, 2'b10, 16'h8013, 16'h7777, 0, 1};
        vecs[12] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h7777, 2'b00, 16'h8013, 16'h7777, 0, 1};

        wa_ready = 2'b11;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            tick();
            check($sformatf("vec%0d", i),
                  {xa_rd_vld, xa_data_rd, wa_wr_s, wa_addr, wa_data_wr, xa_busy, xa_err},
                  {vecs[i].exp_vld, vecs[i].exp_rd, vecs[i].exp_ws, vecs[i].exp_wa,
                   vecs[i].exp_wd, vecs[i].exp_busy, vecs[i].exp_err});
        end

        // Capacity: 1 output slot + 4 queued, sixth write dropped.
        do_reset();
        wa_ready = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b0, 16'(i), 16'h0100 + 16'(i));
            tick();
            if (i == 5) check("cap_busy_after5", {xa_busy, xa_err}, 2'b10);
        end
        check("cap_drop_err", {xa_busy, xa_err}, 2'b11);
        check("cap_head_held", {wa_wr_s, wa_addr, wa_data_wr}, {2'b01, 16'h0001, 16'h0101});
`ifdef SIF_BRIDGE_STATS_EN
        check("cap_drop_cnt", drop_cnt, 8'd1);
`endif
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        wa_ready = 2'b10;
        tick();
        check("cap_other_ready_ignored", {wa_wr_s, wa_addr, xa_busy}, {2'b01, 16'h0001, 1'b1});
        wa_ready = 2'b01;
        for (int j = 2; j <= 5; j++) begin
            tick();
            check($sformatf("cap_drain%0d", j), {wa_wr_s, wa_addr, wa_data_wr},
                  {2'b01, 16'(j), 16'h0100 + 16'(j)});
        end
        tick();
        check("cap_idle", {wa_wr_s, xa_busy, xa_err}, {2'b00, 1'b0, 1'b1});

        // Throughput: 8 back-to-back writes, alternating channels, strobe on 8 consecutive cycles.
        do_reset();
        wa_ready = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) drive(1'b1, 1'b0, ((k % 2) ? 16'h8000 : 16'h0000) | 16'(k), 16'h2000 + 16'(k));
            else        drive(1'b0, 1'b0, 16'h0, 16'h0);
            tick();
            if (k >= 2 && k <= 9)
                check($sformatf("tput_cycle%0d", k), {wa_wr_s, wa_addr, wa_data_wr},
                      {(((k - 1) % 2) ? 2'b10 : 2'b01),
                       ((((k - 1) % 2) ? 16'h8000 : 16'h0000) | 16'(k - 1)),
                       16'h2000 + 16'(k - 1)});
            else
                check($sformatf("tput_cycle%0d", k), wa_wr_s, 2'b00);
        end

        // Asynchronous reset with one entry presented and three queued.
        do_reset();
        wa_ready = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 16'h0010 + 16'(i), 16'h3000 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b1, 16'h0011, 16'h0);
        tick();
        check("arst_pre", {wa_wr_s, wa_addr, xa_rd_vld}, {2'b01, 16'h0011, 1'b1});
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs",
              {xa_rd_vld, xa_data_rd, xa_busy, xa_err, wa_wr_s, wa_addr, wa_data_wr},
              53'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wa_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("arst_no_stale%0d", i), {wa_wr_s, wa_addr}, 18'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
